// File: rtl/buffer_pea_pkg.sv
// Shared types and sizing for the buffer/PE-array crossbar.
// Optional build macro BPX_STATS_EN is consumed by the top level.
package buffer_pea_pkg;

  localparam int N_MODES   = 4;
  localparam int N_BUF     = 4;
  localparam int DATA_W    = 256;
  localparam int ADDR_W    = 10;
  localparam int CTRL_W    = 64;
  localparam int DRAIN_CYC = 4;

  localparam int MS_W  = $clog2(N_MODES);
  localparam int BS_W  = $clog2(N_BUF);
  localparam int BC_W  = 2 + 2 * ADDR_W;
  localparam int CNT_W =
    (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam int MODE_IDLE = 0;

  // Bit i set when index i addresses a real mode/buffer.
  localparam int MODE_SPAN = 1 << MS_W;
  localparam int BUF_SPAN  = 1 << BS_W;
  localparam logic [MODE_SPAN-1:0] MODE_OK =
    MODE_SPAN'((64'd1 << N_MODES) - 64'd1);
  localparam logic [BUF_SPAN-1:0] BUF_OK =
    BUF_SPAN'((64'd1 << N_BUF) - 64'd1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    SETTLE
  } bpx_state_e;

  typedef struct packed {
    logic              r_en;
    logic              w_en;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr;
  } bctrl_t;

  function automatic logic [MS_W-1:0] clamp_mode(
    input logic [MS_W-1:0] s
  );
    return MODE_OK[s] ? s : MS_W'(MODE_IDLE);
  endfunction

  function automatic logic buf_ok(
    input logic [BS_W-1:0] i
  );
    return BUF_OK[i];
  endfunction

endpackage

// File: rtl/buffer_pea_xbar_if.sv
// Mode-change request handshake between the layer sequencer
// and the buffer/PE-array crossbar.
interface buffer_pea_xbar_if;
  import buffer_pea_pkg::*;

  logic            req_valid_i;
  logic [MS_W-1:0] req_sel_i;
  logic            req_swap_i;
  logic            req_ready_o;

  modport master (
    output req_valid_i,
    output req_sel_i,
    output req_swap_i,
    input  req_ready_o
  );

  modport slave (
    input  req_valid_i,
    input  req_sel_i,
    input  req_swap_i,
    output req_ready_o
  );

endinterface

// File: rtl/bpx_mode_fsm.sv
// Mode-switch sequencer: request handshake, drain countdown,
// and the active mode / ping-pong registers.
module bpx_mode_fsm
  import buffer_pea_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  buffer_pea_xbar_if.slave  req,
  output bpx_state_e        state_o,
  output logic [MS_W-1:0]   cur_mode_o,
  output logic              swap_o,
  output logic              busy_o,
  output logic              start_o
);

  bpx_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [MS_W-1:0]  cur_q;
  logic [MS_W-1:0]  sel_q;
  logic             swap_q;
  logic             tgl_q;
  logic             rdy_q;
  logic             busy_q;

  logic [MS_W-1:0]  sel_c;
  logic             acc;

  assign sel_c   = clamp_mode(req.req_sel_i);
  assign acc     = req.req_valid_i & rdy_q;
  assign start_o = acc &
                   ((sel_c != cur_q) | req.req_swap_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
      cur_q   <= MS_W'(MODE_IDLE);
      sel_q   <= MS_W'(MODE_IDLE);
      swap_q  <= 1'b0;
      tgl_q   <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (start_o) begin
            state_q <= DRAIN;
            cnt_q   <= CNT_W'(DRAIN_CYC - 1);
            sel_q   <= sel_c;
            tgl_q   <= req.req_swap_i;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        DRAIN: begin
          if (cnt_q == '0) begin
            state_q <= SETTLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SETTLE: begin
          state_q <= RUN;
          cur_q   <= sel_q;
          swap_q  <= swap_q ^ tgl_q;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign req.req_ready_o = rdy_q;
  assign state_o         = state_q;
  assign cur_mode_o      = cur_q;
  assign swap_o          = swap_q;
  assign busy_o          = busy_q;

endmodule

// File: rtl/buffer_pea_xbar.sv
// Buffer-bank to PE-array crossbar with drained mode switching.
// Define BPX_STATS_EN to add the stat_switch_o switch counter.
module buffer_pea_xbar
  import buffer_pea_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  buffer_pea_xbar_if.slave req,
  output logic [MS_W-1:0] cur_mode_o,
  output logic            busy_o,
  input  bctrl_t [N_MODES-1:0][N_BUF-1:0]
                          mode_bctrl_i,
  input  logic [N_MODES-1:0][CTRL_W-1:0]
                          mode_pctrl_i,
  input  logic [N_MODES-1:0][1:0][BS_W-1:0]
                          mode_src_i,
  input  logic [N_MODES-1:0][BS_W-1:0]
                          mode_dst_i,
  input  logic [N_BUF-1:0][DATA_W-1:0]
                          buf_rdata_i,
  output logic [N_BUF-1:0][DATA_W-1:0]
                          buf_wdata_o,
  output bctrl_t [N_BUF-1:0]
                          buf_ctrl_o,
  output logic [DATA_W-1:0] pea_in1_o,
  output logic [DATA_W-1:0] pea_in2_o,
  input  logic [DATA_W-1:0] pea_out_i,
  output logic [CTRL_W-1:0] pea_ctrl_o
`ifdef BPX_STATS_EN
  ,
  output logic [15:0]     stat_switch_o
`endif
);

  bpx_state_e      state;
  logic [MS_W-1:0] cur;
  logic            swap;
  logic            start;

  bpx_mode_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .state_o    (state),
    .cur_mode_o (cur),
    .swap_o     (swap),
    .busy_o     (busy_o),
    .start_o    (start)
  );

  assign cur_mode_o = cur;

  bctrl_t [N_BUF-1:0] bctrl_d, bctrl_q;
  logic [CTRL_W-1:0]  pctrl_d, pctrl_q;
  logic [BS_W-1:0]    dst;
  logic               dst_ok;

  assign dst    = mode_dst_i[cur];
  assign dst_ok = buf_ok(dst);

  // Control is zeroed from the accepting edge onward.
  always_comb begin
    bctrl_d = '0;
    pctrl_d = '0;
    if (state == RUN && !start &&
        cur != MS_W'(MODE_IDLE)) begin
      pctrl_d = mode_pctrl_i[cur];
      for (int b = 0; b < N_BUF; b++) begin
        bctrl_d[b] = mode_bctrl_i[cur][b];
        if (!dst_ok || dst != BS_W'(b)) begin
          bctrl_d[b].w_en = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bctrl_q <= '0;
      pctrl_q <= '0;
    end else begin
      bctrl_q <= bctrl_d;
      pctrl_q <= pctrl_d;
    end
  end

  assign buf_ctrl_o = bctrl_q;
  assign pea_ctrl_o = pctrl_q;

  logic [1:0][BS_W-1:0] src;
  logic [BS_W-1:0]      s1;
  logic [BS_W-1:0]      s2;

  assign src = mode_src_i[cur];
  assign s1  = src[swap];
  assign s2  = src[~swap];

  assign pea_in1_o =
    buf_ok(s1) ? buf_rdata_i[s1] : '0;
  assign pea_in2_o =
    buf_ok(s2) ? buf_rdata_i[s2] : '0;

  assign buf_wdata_o = {N_BUF{pea_out_i}};

`ifdef BPX_STATS_EN
  logic [15:0] stat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else if (state == SETTLE &&
                 stat_q != 16'hFFFF) begin
      stat_q <= stat_q + 16'd1;
    end
  end

  assign stat_switch_o = stat_q;
`endif

endmodule

// File: tb/tb_buffer_pea_xbar.sv
// Self-checking bench for buffer_pea_xbar: directed mode
// switches plus randomized traffic against a reference model.
module tb_buffer_pea_xbar;
  import buffer_pea_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  buffer_pea_xbar_if bif ();

  logic [MS_W-1:0] cur_mode;
  logic            busy;
  bctrl_t [N_MODES-1:0][N_BUF-1:0] mode_bctrl;
  logic [N_MODES-1:0][CTRL_W-1:0]  mode_pctrl;
  logic [N_MODES-1:0][1:0][BS_W-1:0] mode_src;
  logic [N_MODES-1:0][BS_W-1:0]    mode_dst;
  logic [N_BUF-1:0][DATA_W-1:0]    rdata;
  logic [N_BUF-1:0][DATA_W-1:0]    wdata;
  bctrl_t [N_BUF-1:0]              bctrl;
  logic [DATA_W-1:0] in1, in2, pout;
  logic [CTRL_W-1:0] pctrl;
`ifdef BPX_STATS_EN
  logic [15:0] stat;
`endif

  buffer_pea_xbar dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (bif),
    .cur_mode_o   (cur_mode),
    .busy_o       (busy),
    .mode_bctrl_i (mode_bctrl),
    .mode_pctrl_i (mode_pctrl),
    .mode_src_i   (mode_src),
    .mode_dst_i   (mode_dst),
    .buf_rdata_i  (rdata),
    .buf_wdata_o  (wdata),
    .buf_ctrl_o   (bctrl),
    .pea_in1_o    (in1),
    .pea_in2_o    (in2),
    .pea_out_i    (pout),
    .pea_ctrl_o   (pctrl)
`ifdef BPX_STATS_EN
    ,
    .stat_switch_o(stat)
`endif
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference model: a switch is a countdown of DRAIN_CYC+1
  // unready cycles; control follows the mode one edge late.
  int m_cur, m_left, p_sel;
  bit m_swap, p_swap;
  bctrl_t [N_BUF-1:0] exp_bctrl;
  logic [CTRL_W-1:0]  exp_pctrl;

  always @(posedge clk or negedge rst_n) begin : model
    int sel;
    bit go;
    if (!rst_n) begin
      m_cur = 0; m_left = 0; m_swap = 0;
      p_sel = 0; p_swap = 0;
      exp_bctrl = '0; exp_pctrl = '0;
    end else begin
      sel = int'(bif.req_sel_i);
      if (sel >= N_MODES) sel = 0;
      go = bif.req_valid_i && m_left == 0 &&
           (sel != m_cur || bif.req_swap_i);
      exp_bctrl = '0;
      exp_pctrl = '0;
      if (m_left == 0 && !go && m_cur != 0) begin
        exp_pctrl = mode_pctrl[m_cur];
        for (int b = 0; b < N_BUF; b++) begin
          exp_bctrl[b] = mode_bctrl[m_cur][b];
          if (int'(mode_dst[m_cur]) >= N_BUF ||
              int'(mode_dst[m_cur]) != b)
            exp_bctrl[b].w_en = 1'b0;
        end
      end
      if (go) begin
        m_left = DRAIN_CYC + 1;
        p_sel  = sel;
        p_swap = bif.req_swap_i;
      end else if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_cur  = p_sel;
          m_swap = m_swap ^ p_swap;
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] pick(int idx);
    return (idx < N_BUF) ? rdata[idx] : '0;
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("ready", 256'(bif.req_ready_o),
          256'(m_left == 0));
      chk("busy", 256'(busy), 256'(m_left != 0));
      chk("cur", 256'(cur_mode), 256'(m_cur));
      chk("pctrl", 256'(pctrl), 256'(exp_pctrl));
      chk("bctrl", 256'(bctrl), 256'(exp_bctrl));
      chk("in1", in1,
          pick(int'(mode_src[m_cur][m_swap])));
      chk("in2", in2,
          pick(int'(mode_src[m_cur][!m_swap])));
      for (int b = 0; b < N_BUF; b++)
        chk("wdata", wdata[b], pout);
    end
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic fixed_tables();
    for (int m = 0; m < N_MODES; m++) begin
      for (int b = 0; b < N_BUF; b++) begin
        mode_bctrl[m][b].r_en   = 1'b1;
        mode_bctrl[m][b].w_en   = 1'b1;
        mode_bctrl[m][b].r_addr = ADDR_W'(m * 16 + b);
        mode_bctrl[m][b].w_addr = ADDR_W'(100 + m * 16 + b);
      end
      mode_pctrl[m] = 64'hC0DE_0000_0000_0000 | 64'(m);
      mode_src[m][0] = BS_W'(m);
      mode_src[m][1] = BS_W'(m + 1);
    end
    mode_src[1][0] = 2'd0;
    mode_src[1][1] = 2'd2;
    mode_dst[0] = 2'd0;
    mode_dst[1] = 2'd1;
    mode_dst[2] = 2'd3;
    mode_dst[3] = 2'd0;
    for (int b = 0; b < N_BUF; b++)
      rdata[b] = {8{32'hB0B0_0000 | 32'(b)}};
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!bif.req_ready_o && n < 30) begin
      tick();
      n++;
    end
    chk("ready_timeout", 256'(bif.req_ready_o), 256'(1));
  endtask

  task automatic request(int sel, bit swp);
    bif.req_valid_i = 1'b1;
    bif.req_sel_i   = MS_W'(sel);
    bif.req_swap_i  = swp;
    tick();
    bif.req_valid_i = 1'b0;
    bif.req_swap_i  = 1'b0;
  endtask

  initial begin
    int lo, zero;
    bctrl_t e;
    rst_n = 1'b0;
    bif.req_valid_i = 1'b0;
    bif.req_sel_i   = '0;
    bif.req_swap_i  = 1'b0;
    pout = rnd256();
    fixed_tables();
    tick();
    check_en = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 256'(bif.req_ready_o), 256'(1));
    chk("rst_cur", 256'(cur_mode), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_bctrl", 256'(bctrl), 256'(0));
    chk("rst_pctrl", 256'(pctrl), 256'(0));

    // Mode 0 -> 1
    request(1, 1'b0);
    lo = 0; zero = 0;
    for (int k = 0; k < 6; k++) begin
      if (!bif.req_ready_o) lo++;
      if (bctrl == '0 && pctrl == '0) zero++;
      tick();
    end
    chk("sw_ready_low", 256'(lo), 256'(5));
    chk("sw_zero_cyc", 256'(zero), 256'(6));
    e = '{1'b1, 1'b0, 10'd16, 10'd116};
    chk("sw_b0", 256'(bctrl[0]), 256'(e));
    e = '{1'b1, 1'b1, 10'd17, 10'd117};
    chk("sw_b1", 256'(bctrl[1]), 256'(e));
    chk("sw_pctrl", 256'(pctrl),
        256'(64'hC0DE_0000_0000_0001));
    chk("m1_in1", in1, {8{32'hB0B0_0000}});
    chk("m1_in2", in2, {8{32'hB0B0_0002}});

    // Ping-pong swap within mode 1
    request(1, 1'b1);
    wait_ready();
    chk("swap_in1", in1, {8{32'hB0B0_0002}});
    chk("swap_in2", in2, {8{32'hB0B0_0000}});

    // Same mode, no swap: no drain
    request(1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("noop_busy", 256'(busy), 256'(0));
      chk("noop_b1", 256'(bctrl[1]), 256'(e));
      tick();
    end

    // Mode 2, dst 3: only buffer 3 writes
    request(2, 1'b0);
    wait_ready();
    tick();
    for (int b = 0; b < N_BUF; b++)
      chk("dst_wen", 256'(bctrl[b].w_en),
          256'(b == 3));

    // Request held across a drain stays pending
    bif.req_valid_i = 1'b1;
    bif.req_sel_i   = 2'd3;
    tick();
    bif.req_sel_i   = 2'd0;
    wait_ready();
    chk("held_cur3", 256'(cur_mode), 256'(3));
    tick();
    bif.req_valid_i = 1'b0;
    chk("held_busy", 256'(busy), 256'(1));
    wait_ready();
    chk("held_cur0", 256'(cur_mode), 256'(0));

    // Reset mid-drain aborts the switch
    request(2, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rd_ready", 256'(bif.req_ready_o), 256'(1));
    chk("rd_busy", 256'(busy), 256'(0));
    chk("rd_cur", 256'(cur_mode), 256'(0));
    tick();
    chk("rd_bctrl", 256'(bctrl), 256'(0));
    chk("rd_pctrl", 256'(pctrl), 256'(0));
    rst_n = 1'b1;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int m = 0; m < N_MODES; m++) begin
        for (int b = 0; b < N_BUF; b++)
          mode_bctrl[m][b] = BC_W'($urandom);
        mode_pctrl[m] = {$urandom, $urandom};
        mode_src[m][0] = BS_W'($urandom);
        mode_src[m][1] = BS_W'($urandom);
        mode_dst[m] = BS_W'($urandom);
      end
      for (int b = 0; b < N_BUF; b++) rdata[b] = rnd256();
      pout = rnd256();
      bif.req_valid_i = ($urandom_range(0, 3) == 0);
      bif.req_sel_i   = MS_W'($urandom);
      bif.req_swap_i  = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
